// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM download streamer: writer FSM states and FIFO entry layout.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        StResync,
        StIdle,
        StWait
    } writer_state_e;

    typedef struct packed {
        logic [31:0] din;
        logic [3:0]  be;
    } entry_t;

    localparam logic [3:0] BeFull = 4'hF;
    localparam logic [3:0] BeHalf = 4'h3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/rom_loader_fifo.sv
// Small synchronous FIFO holding packed SDRAM write entries (data + byte enables).
module rom_loader_fifo
    import rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  entry_t                   i_data,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    entry_t              r_mem [DEPTH];
    logic [PtrW-1:0]     r_wptr;
    logic [PtrW-1:0]     r_rptr;
    logic [CntW-1:0]     r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CntW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams HPS ioctl downloads into SDRAM: packs 16-bit words into 32-bit writes,
// buffers them, issues toggle-handshake writes and reports completion and size.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [5:0]  INDEX_MAX  = 6'h01,
    parameter logic [24:0] BASE_ADDR  = 25'h0
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [15:0] i_ioctl_dout,
    output logic        o_ioctl_wait,
    output logic [24:0] o_sdram_waddr,
    output logic [31:0] o_sdram_din,
    output logic [3:0]  o_sdram_be,
    output logic        o_sdram_we_req,
    input  logic        i_sdram_we_ack,
    output logic        o_loading,
    output logic        o_done,
    output logic [24:0] o_rom_size
);

    localparam int unsigned    CntW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] WaitLevel = CntW'(FIFO_DEPTH - 1);
    localparam logic [24:0]    SizeMax   = 25'h1000000;

    logic            w_sel;
    logic            w_start;
    logic            w_end;
    logic            w_unused;

    logic            r_sel_q;
    logic            r_pk_full;
    logic [15:0]     r_pk_lo;

    logic            w_push_req;
    logic            w_push;
    entry_t          w_push_entry;
    entry_t          w_head;
    logic [CntW-1:0] w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;

    writer_state_e   r_state;
    writer_state_e   w_state_d;
    logic            w_issue;
    logic            w_pop;

    logic [23:0]     r_offset;
    logic [24:0]     r_rom_size;
    logic [24:0]     w_rom_sum;
    logic            r_pend;
    logic            w_pend_d;
    logic            w_busy;
    logic            w_clear;
    logic            r_wait;
    logic            r_loading;
    logic            r_done;
    logic            w_done_cond;

    logic [24:0]     r_waddr;
    logic [31:0]     r_din;
    logic [3:0]      r_be;
    logic            r_req;

    assign w_unused = ^i_ioctl_index[7:6];

    assign w_sel   = i_ioctl_download & (i_ioctl_index[5:0] <= INDEX_MAX);
    assign w_start = w_sel & ~r_sel_q;
    assign w_end   = ~w_sel & r_sel_q;

    // A word arriving on the start cycle opens a fresh pair rather than completing an old one.
    assign w_push_req = (i_ioctl_wr & w_sel & r_pk_full & ~w_start) | (w_end & r_pk_full);
    assign w_push     = w_push_req & ~w_fifo_full;

    always_comb begin
        w_push_entry     = '0;
        w_push_entry.din = {i_ioctl_dout, r_pk_lo};
        w_push_entry.be  = BeFull;
        if (w_end) begin
            w_push_entry.din = {16'h0000, r_pk_lo};
            w_push_entry.be  = BeHalf;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_sel_q   <= 1'b0;
            r_pk_full <= 1'b0;
            r_pk_lo   <= 16'h0000;
        end else begin
            r_sel_q <= w_sel;
            if (i_ioctl_wr && w_sel) begin
                if (r_pk_full && !w_start) begin
                    r_pk_full <= 1'b0;
                end else begin
                    r_pk_lo   <= i_ioctl_dout;
                    r_pk_full <= 1'b1;
                end
            end else if (w_start || w_end) begin
                r_pk_full <= 1'b0;
            end
        end
    end

    rom_loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state <= StResync;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        w_pop     = 1'b0;
        unique case (r_state)
            StResync: begin
                if (i_sdram_we_ack == r_req) begin
                    w_state_d = StIdle;
                end
            end
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_issue   = 1'b1;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (i_sdram_we_ack == r_req) begin
                    w_pop     = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StResync;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_waddr <= BASE_ADDR;
            r_din   <= 32'h0;
            r_be    <= BeFull;
            r_req   <= 1'b0;
        end else if (w_issue) begin
            r_waddr <= BASE_ADDR + {1'b0, r_offset};
            r_din   <= w_head.din;
            r_be    <= w_head.be;
            r_req   <= ~r_req;
        end
    end

    // A restart is deferred until every old entry is committed at its old address.
    assign w_busy    = ~w_fifo_empty | (r_state != StIdle);
    assign w_clear   = (w_start | r_pend) & ~w_busy;
    assign w_pend_d  = (w_start | r_pend) & w_busy;
    assign w_rom_sum = r_rom_size + 25'(popcount4(r_be));

    assign w_done_cond = ~w_sel & w_fifo_empty & ~r_pk_full & (r_state == StIdle) & r_loading;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_offset   <= 24'h0;
            r_rom_size <= 25'h0;
            r_pend     <= 1'b0;
            r_wait     <= 1'b0;
            r_loading  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pend <= w_pend_d;
            r_wait <= (w_fifo_count >= WaitLevel) | w_pend_d;
            r_done <= w_done_cond;
            if (w_clear) begin
                r_offset   <= 24'h0;
                r_rom_size <= 25'h0;
            end else if (w_pop) begin
                r_offset   <= r_offset + 24'd4;
                r_rom_size <= (w_rom_sum >= SizeMax) ? SizeMax : w_rom_sum;
            end
            if (w_start) begin
                r_loading <= 1'b1;
            end else if (w_done_cond) begin
                r_loading <= 1'b0;
            end
        end
    end

    assign o_ioctl_wait   = r_wait;
    assign o_sdram_waddr  = r_waddr;
    assign o_sdram_din    = r_din;
    assign o_sdram_be     = r_be;
    assign o_sdram_we_req = r_req;
    assign o_loading      = r_loading;
    assign o_done         = r_done;
    assign o_rom_size     = r_rom_size;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a toggle-ack SDRAM model and write capture.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [24:0] sdram_waddr;
    logic [31:0] sdram_din;
    logic [3:0]  sdram_be;
    logic        sdram_we_req;
    bit          sdram_we_ack;
    logic        loading;
    logic        done;
    logic [24:0] rom_size;

    typedef struct {
        logic [24:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } wr_t;

    wr_t         wq[$];
    wr_t         cap;
    bit          cap_v;
    int          n_cmp;
    int          n_bad;
    int          toggles;
    int          done_cnt;
    int          viol_busy;
    int          viol_stab;
    int          viol_full;
    int          viol_wait;
    bit          chk_wait;
    bit          saw_wait;
    int          prev_cnt;
    logic        prev_req;
    bit          prev_ack;
    int unsigned ack_lat = 3;
    int unsigned ack_cnt;

    rom_loader dut (
        .i_clk_sys        (clk),
        .i_reset          (reset),
        .i_ioctl_download (ioctl_download),
        .i_ioctl_index    (ioctl_index),
        .i_ioctl_wr       (ioctl_wr),
        .i_ioctl_dout     (ioctl_dout),
        .o_ioctl_wait     (ioctl_wait),
        .o_sdram_waddr    (sdram_waddr),
        .o_sdram_din      (sdram_din),
        .o_sdram_be       (sdram_be),
        .o_sdram_we_req   (sdram_we_req),
        .i_sdram_we_ack   (sdram_we_ack),
        .o_loading        (loading),
        .o_done           (done),
        .o_rom_size       (rom_size)
    );

    always #5 clk = ~clk;

    // SDRAM model: ack follows req ack_lat cycles later; not reset with the DUT.
    always @(posedge clk) begin
        if (sdram_we_ack != sdram_we_req) begin
            if (ack_cnt + 1 >= ack_lat) begin
                sdram_we_ack <= sdram_we_req;
                ack_cnt      <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                cap_v = 1'b0;
            end else begin
                if (sdram_we_req !== prev_req) begin
                    toggles++;
                    if (prev_ack != prev_req) viol_busy++;
                    cap = '{sdram_waddr, sdram_din, sdram_be};
                    wq.push_back(cap);
                    cap_v = 1'b1;
                end else if (cap_v) begin
                    if (sdram_we_ack == sdram_we_req) cap_v = 1'b0;
                    else if (sdram_waddr !== cap.a || sdram_din !== cap.d || sdram_be !== cap.b)
                        viol_stab++;
                end
                if (done) done_cnt++;
                if (dut.w_push_req && dut.w_fifo_full) viol_full++;
                if (chk_wait && (ioctl_wait !== (prev_cnt >= 3))) viol_wait++;
            end
            prev_req = sdram_we_req;
            prev_ack = sdram_we_ack;
            prev_cnt = int'(dut.w_fifo_count);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int g = 0;
        while (ioctl_wait && g < 200) begin
            saw_wait = 1'b1;
            tick();
            g++;
        end
        chk("wait_bound", 32'(g < 200), 1);
        ioctl_wr   = 1'b1;
        ioctl_dout = w;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (loading && g < 1000) begin
            tick();
            g++;
        end
        chk(tag, 32'(g < 1000), 1);
        tick();
        tick();
    endtask

    task automatic chk_wr(input int i, input logic [24:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        if (i < wq.size()) begin
            chk($sformatf("wr%0d_addr", i), 32'(wq[i].a), 32'(a));
            chk($sformatf("wr%0d_din", i), wq[i].d, d);
            chk($sformatf("wr%0d_be", i), 32'(wq[i].b), 32'(b));
        end else begin
            chk($sformatf("wr%0d_present", i), wq.size(), i + 1);
        end
    endtask

    task automatic new_phase();
        wq.delete();
        toggles  = 0;
        done_cnt = 0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_wait"}, 32'(ioctl_wait), 0);
        chk({p, "_req"}, 32'(sdram_we_req), 0);
        chk({p, "_be"}, 32'(sdram_be), 32'hF);
        chk({p, "_waddr"}, 32'(sdram_waddr), 0);
        chk({p, "_din"}, sdram_din, 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_loading"}, 32'(loading), 0);
        chk({p, "_rom_size"}, 32'(rom_size), 0);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_reset_vals("rst");

        // 8 words -> 4 full writes
        new_phase();
        ack_lat        = 3;
        ioctl_download = 1'b1;
        tick();
        chk("t1_loading", 32'(loading), 1);
        for (int i = 0; i < 8; i++) begin
            send_word(16'h1100 + 16'(i));
            tick();
        end
        ioctl_download = 1'b0;
        wait_idle("t1_drain");
        chk("t1_nwr", wq.size(), 4);
        chk_wr(0, 25'h0, 32'h11011100, 4'hF);
        chk_wr(1, 25'h4, 32'h11031102, 4'hF);
        chk_wr(2, 25'h8, 32'h11051104, 4'hF);
        chk_wr(3, 25'hC, 32'h11071106, 4'hF);
        chk("t1_rom_size", 32'(rom_size), 16);
        chk("t1_done", done_cnt, 1);

        // 5 words -> trailing half word
        new_phase();
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            send_word(16'h1100 + 16'(i));
            tick();
        end
        ioctl_download = 1'b0;
        wait_idle("t2_drain");
        chk("t2_nwr", wq.size(), 3);
        chk_wr(1, 25'h4, 32'h11031102, 4'hF);
        chk_wr(2, 25'h8, 32'h00001104, 4'h3);
        chk("t2_rom_size", 32'(rom_size), 10);
        chk("t2_done", done_cnt, 1);

        // back-to-back writes with slow ack -> throttling
        new_phase();
        ack_lat        = 20;
        saw_wait       = 1'b0;
        chk_wait       = 1'b1;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send_word(16'h3300 + 16'(i));
        ioctl_download = 1'b0;
        wait_idle("t3_drain");
        chk_wait = 1'b0;
        chk("t3_nwr", wq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk_wr(i, 25'(4 * i), {16'h3301 + 16'(2 * i), 16'h3300 + 16'(2 * i)}, 4'hF);
        end
        chk("t3_rom_size", 32'(rom_size), 32);
        chk("t3_saw_wait", 32'(saw_wait), 1);
        chk("t3_wait_timing", viol_wait, 0);

        // unselected index is ignored
        new_phase();
        ioctl_index    = 8'h02;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send_word(16'h4400 + 16'(i));
        ioctl_download = 1'b0;
        repeat (10) tick();
        chk("t4_toggles", toggles, 0);
        chk("t4_done", done_cnt, 0);
        chk("t4_loading", 32'(loading), 0);
        chk("t4_rom_size", 32'(rom_size), 32);
        ioctl_index = 8'h00;

        // reset in WAIT with ack lagging
        new_phase();
        ioctl_download = 1'b1;
        tick();
        send_word(16'h5A00);
        send_word(16'h5A01);
        begin
            int g = 0;
            while (toggles == 0 && g < 50) begin
                tick();
                g++;
            end
            chk("t5_issue_bound", 32'(g < 50), 1);
        end
        tick();
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("t5_rst");
        chk("t5_ack_lag", 32'(sdram_we_ack), 1);
        new_phase();
        viol_busy      = 0;
        ioctl_download = 1'b1;
        tick();
        send_word(16'h5500);
        send_word(16'h5501);
        ioctl_download = 1'b0;
        wait_idle("t5_drain");
        chk("t5_busy_toggle", viol_busy, 0);
        chk("t5_nwr", wq.size(), 1);
        chk_wr(0, 25'h0, 32'h55015500, 4'hF);
        chk("t5_rom_size", 32'(rom_size), 4);
        chk("t5_done", done_cnt, 1);

        // restart while old entries are still pending
        new_phase();
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send_word(16'h6600 + 16'(i));
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        tick();
        chk("t6_restart_wait", 32'(ioctl_wait), 1);
        begin
            int g = 0;
            while (ioctl_wait && g < 500) begin
                tick();
                g++;
            end
            chk("t6_wait_bound", 32'(g < 500), 1);
        end
        chk("t6_old_drained", wq.size(), 3);
        chk("t6_rom_restart", 32'(rom_size), 0);
        send_word(16'h7700);
        send_word(16'h7701);
        ioctl_download = 1'b0;
        wait_idle("t6_drain");
        chk_wr(0, 25'h0, 32'h66016600, 4'hF);
        chk_wr(1, 25'h4, 32'h66036602, 4'hF);
        chk_wr(2, 25'h8, 32'h66056604, 4'hF);
        chk_wr(3, 25'h0, 32'h77017700, 4'hF);
        chk("t6_nwr", wq.size(), 4);
        chk("t6_rom_size", 32'(rom_size), 4);
        chk("t6_done", done_cnt, 1);

        chk("push_while_full", viol_full, 0);
        chk("data_stable_in_wait", viol_stab, 0);
        chk("req_toggle_while_busy", viol_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
